// File: rtl/psc_edge_stream.sv
// psc_edge_stream: edge converter between host-side parallel words and
// slice-serial lanes toward/from the tile array. Serialize (LOAD->SHIFT)
// and deserialize (CAPTURE->PRESENT) share one control FSM.
module psc_edge_stream #(
  parameter  int unsigned CHANNELS    = 4,
  parameter  int unsigned WORD_LENGTH = 32,
  parameter  int unsigned SLICE_SIZE  = 4,
  localparam int unsigned NSLICE      = WORD_LENGTH / SLICE_SIZE,
  localparam int unsigned CW          = $clog2(NSLICE + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      mode,
  input  logic                            start,
  input  logic                            msb_first,
  input  logic [CHANNELS*WORD_LENGTH-1:0] par_in,
  input  logic                            par_in_valid,
  output logic                            par_in_ready,
  output logic [CHANNELS*SLICE_SIZE-1:0]  ser_out,
  output logic                            ser_out_valid,
  input  logic [CHANNELS*SLICE_SIZE-1:0]  ser_in,
  input  logic                            ser_in_valid,
  output logic [CHANNELS*WORD_LENGTH-1:0] par_out,
  output logic                            par_out_valid,
  input  logic                            par_out_ready,
  output logic                            busy,
  output logic                            done,
  output logic [CW-1:0]                   slice_cnt
);

  localparam int unsigned BW  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam int unsigned PW  = CHANNELS * WORD_LENGTH;
  localparam int unsigned SW  = CHANNELS * SLICE_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t        state;
  logic          msb_q;
  logic [PW-1:0] sh_q;
  logic [PW-1:0] cap_q;
  logic [PW-1:0] cap_next;
  logic [SW-1:0] ser_next;
  logic [CW-1:0] rd_k;
  logic [BW-1:0] rd_base;
  logic [BW-1:0] wr_base;

  // Bit offset inside a lane word of the slice to emit next / store now
  always_comb begin
    rd_k    = (state == S_SHIFT) ? slice_cnt + CW'(1) : '0;
    rd_base = msb_q ? BW'((NSLICE - 1 - 32'(rd_k)) * SLICE_SIZE)
                    : BW'(32'(rd_k) * SLICE_SIZE);
    wr_base = msb_q ? BW'((NSLICE - 1 - 32'(slice_cnt)) * SLICE_SIZE)
                    : BW'(32'(slice_cnt) * SLICE_SIZE);
  end

  // Per-lane slice extraction and insertion; lanes never interact
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WORD_LENGTH-1:0] src_w;
    logic [WORD_LENGTH-1:0] cap_w;

    // In LOAD the first slice comes straight from par_in so it can be
    // registered on the handshake edge itself
    assign src_w = (state == S_LOAD) ? par_in[c*WORD_LENGTH +: WORD_LENGTH]
                                     : sh_q[c*WORD_LENGTH +: WORD_LENGTH];
    assign ser_next[c*SLICE_SIZE +: SLICE_SIZE] = src_w[rd_base +: SLICE_SIZE];

    // Capture word with the incoming slice merged at its position
    always_comb begin
      cap_w = cap_q[c*WORD_LENGTH +: WORD_LENGTH];
      cap_w[wr_base +: SLICE_SIZE] = ser_in[c*SLICE_SIZE +: SLICE_SIZE];
    end

    assign cap_next[c*WORD_LENGTH +: WORD_LENGTH] = cap_w;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      msb_q         <= 1'b0;
      sh_q          <= '0;
      cap_q         <= '0;
      par_in_ready  <= 1'b0;
      ser_out       <= '0;
      ser_out_valid <= 1'b0;
      par_out       <= '0;
      par_out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      slice_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (mode == 2'b01)) begin
            state        <= S_LOAD;
            msb_q        <= msb_first;
            par_in_ready <= 1'b1;
            busy         <= 1'b1;
            slice_cnt    <= '0;
          end else if (start && (mode == 2'b10)) begin
            state     <= S_CAPTURE;
            msb_q     <= msb_first;
            busy      <= 1'b1;
            slice_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (par_in_valid && par_in_ready) begin
            state         <= S_SHIFT;
            sh_q          <= par_in;
            par_in_ready  <= 1'b0;
            ser_out       <= ser_next;
            ser_out_valid <= 1'b1;
            slice_cnt     <= '0;
          end
        end
        S_SHIFT: begin
          slice_cnt <= slice_cnt + CW'(1);
          if (slice_cnt == CW'(NSLICE - 1)) begin
            state         <= S_DONE;
            ser_out       <= '0;
            ser_out_valid <= 1'b0;
            done          <= 1'b1;
          end else begin
            ser_out <= ser_next;
          end
        end
        S_CAPTURE: begin
          if (ser_in_valid) begin
            cap_q     <= cap_next;
            slice_cnt <= slice_cnt + CW'(1);
            if (slice_cnt == CW'(NSLICE - 1)) begin
              state         <= S_PRESENT;
              par_out       <= cap_next;
              par_out_valid <= 1'b1;
            end
          end
        end
        S_PRESENT: begin
          if (par_out_ready) begin
            state         <= S_DONE;
            par_out_valid <= 1'b0;
            done          <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          slice_cnt <= '0;
        end
        default: begin
          state         <= S_IDLE;
          par_in_ready  <= 1'b0;
          ser_out       <= '0;
          ser_out_valid <= 1'b0;
          par_out_valid <= 1'b0;
          busy          <= 1'b0;
          slice_cnt     <= '0;
        end
      endcase
    end
  end

endmodule
